uart_tx_buffered: RTL and testbench
===================================

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 The module SHALL have parameter BIT_RATE, default 9600, giving the serial bit rate in bits/s.
REQ-002 The module SHALL have parameter CLK_HZ, default 50_000_000, giving the clk frequency in Hz.
REQ-003 The module SHALL have parameter PAYLOAD_BITS, default 8, giving data bits per frame; legal range 5..8.
REQ-004 The module SHALL have parameter STOP_BITS, default 1, giving stop bits per frame; legal values 1 or 2.
REQ-005 The module SHALL have parameter FIFO_DEPTH, default 16, giving byte FIFO entries; power of 2, at least 2.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-008 The module SHALL have port tx_en, input, 1 bit: enables starting new frames.
REQ-009 The module SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-010 The module SHALL have port in_data, input, 8 bits: the byte to send; only bits [PAYLOAD_BITS-1:0] are transmitted.
REQ-011 The module SHALL have port in_ready, output, 1 bit: high when the FIFO is not full.
REQ-012 The module SHALL have port uart_txd, output, 1 bit: the serial line, idle high.
REQ-013 The module SHALL have port tx_busy, output, 1 bit: high while a frame is on the line.
REQ-014 The module SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the number of FIFO entries.

Function
REQ-015 The module SHALL define CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer division); every line bit lasts exactly CYCLES_PER_BIT clk cycles.
REQ-016 A push SHALL occur on any cycle with in_valid && in_ready; in_data is captured at the FIFO write pointer.
REQ-017 in_ready SHALL be combinationally equal to (fifo_count != FIFO_DEPTH); with in_valid high while full, nothing is written and no error is flagged.
REQ-018 A byte pushed in cycle N SHALL be available to pop no earlier than cycle N+1 (no fall-through).
REQ-019 Pointers SHALL wrap modulo FIFO_DEPTH; push and pop in the same cycle leave fifo_count unchanged.
REQ-020 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-021 IDLE -> START SHALL occur when tx_en && fifo_count != 0; the head byte is popped into a shift register in the same cycle.
REQ-022 START SHALL drive uart_txd=0 for CYCLES_PER_BIT cycles, then move to DATA.
REQ-023 DATA SHALL shift out PAYLOAD_BITS bits LSB first, each for CYCLES_PER_BIT cycles, then move to STOP.
REQ-024 STOP SHALL drive uart_txd=1 for STOP_BITS*CYCLES_PER_BIT cycles, then move to IDLE.
REQ-025 The frame length SHALL be (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles.
REQ-026 Back-to-back frames SHALL have exactly one IDLE cycle between the last stop-bit cycle and the next start bit.
REQ-027 uart_txd SHALL be registered, and SHALL be 1 in IDLE.
REQ-028 tx_busy SHALL be high in START, DATA and STOP, and low in IDLE.
REQ-029 Deasserting tx_en mid-frame SHALL let the current frame complete; no new pop occurs while tx_en is low.
REQ-030 A bit counter SHALL count 0..PAYLOAD_BITS-1.
REQ-031 A cycle counter SHALL be $clog2(CYCLES_PER_BIT*STOP_BITS)+1 bits wide and SHALL reload at each bit boundary.

Reset
REQ-032 While reset=1 at a clk edge: FSM to IDLE; uart_txd=1; tx_busy=0; fifo_count=0; pointers and counters=0; in_ready=1 from the next cycle.
REQ-033 Reset mid-frame SHALL abort the frame: uart_txd is 1 on the cycle after the reset edge, and FIFO contents are discarded.
REQ-034 A push presented during a reset cycle SHALL be ignored.

Verification (CLK_HZ=1_000_000, BIT_RATE=100_000 -> 10 cycles/bit; PAYLOAD_BITS=8, STOP_BITS=1, FIFO_DEPTH=4 unless noted)
REQ-035 tx_en=1, push 0x55 once -> one IDLE cycle, then 10 start cycles at 0, bits 1,0,1,0,1,0,1,0 at 10 cycles each, then 10 stop cycles at 1; tx_busy high for exactly 100 cycles.
REQ-036 tx_en=0, push 5 bytes 0x01..0x05 on consecutive cycles -> fifth push refused (in_ready=0), fifo_count=4; set tx_en=1 -> frames 0x01..0x04 sent with 1 idle cycle between them; fifo_count ends at 0.
REQ-037 During a frame, push and pop coincide at fifo_count=2 -> fifo_count stays 2; wrap-around after 6 total pushes sends bytes in push order.
REQ-038 Drop tx_en at cycle 35 of frame 0xA3 with 2 queued bytes -> 0xA3 completes at cycle 100; line stays idle high; fifo_count=2.
REQ-039 Assert reset at cycle 50 of a frame with 3 queued bytes -> next cycle uart_txd=1, tx_busy=0, fifo_count=0, in_ready=1; no further frames.
REQ-040 STOP_BITS=2, PAYLOAD_BITS=7, push 0xFF -> line shows 7 data bits, all 1, and the frame is 100 cycles (20 stop cycles).

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1-style serializer with
// configurable payload width and stop-bit count.
module uart_tx_buffered #(
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          uart_txd,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CPB = CLK_HZ / BIT_RATE;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(CPB * STOP_BITS) + 1;
  localparam int unsigned BW  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CPB * STOP_BITS - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [PW:0]   CNT_FULL  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;

  state_t        state, state_n;
  logic [CW-1:0] cyc, cyc_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          txd, txd_n;

  assign in_ready = (fifo_count != CNT_FULL);
  assign push     = in_valid && in_ready && !reset;
  assign uart_txd = txd;
  assign tx_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      txd     <= txd_n;
    end
  end

  // txd_n is the line level for the state being entered, so the registered
  // output lines up with the registered state.
  always_comb begin
    state_n = state;
    cyc_n   = cyc + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    txd_n   = txd;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cyc_n = '0;
        txd_n = 1'b1;
        if (tx_en && fifo_count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          state_n = START;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (cyc == BIT_LAST) begin
          cyc_n   = '0;
          bit_n   = '0;
          state_n = DATA;
          txd_n   = shift[0];
        end
      end
      DATA: begin
        if (cyc == BIT_LAST) begin
          cyc_n = '0;
          if (bit_idx == DATA_LAST) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_n   = bit_idx + 1'b1;
            shift_n = shift >> 1;
            txd_n   = shift[1];
          end
        end
      end
      STOP: begin
        if (cyc == STOP_LAST) begin
          cyc_n   = '0;
          state_n = IDLE;
          txd_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: 10 clk cycles per bit, 4-entry FIFO,
// plus a 7-bit / 2-stop-bit instance.
module tb_uart_tx_buffered;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, uart_txd, tx_busy;
  logic [2:0] fifo_count;

  logic       tx_en2 = 1'b0;
  logic       in_valid2 = 1'b0;
  logic [7:0] in_data2 = '0;
  logic       in_ready2, uart_txd2, tx_busy2;
  logic [2:0] fifo_count2;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_buffered #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .uart_txd(uart_txd), .tx_busy(tx_busy), .fifo_count(fifo_count));

  uart_tx_buffered #(.BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(7),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .tx_en(tx_en2), .in_valid(in_valid2), .in_data(in_data2),
    .in_ready(in_ready2), .uart_txd(uart_txd2), .tx_busy(tx_busy2), .fifo_count(fifo_count2));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line[i] = i-th bit on the wire: start, d0..d7, stop
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    tx_en    = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Called on the first START cycle; optionally pushes bytes, drops tx_en,
  // or asserts reset partway through the frame.
  task automatic frame(input logic [9:0] line, input int push_cyc, input logic [7:0] push_d,
                       input int push_n, input int drop_cyc, input int abort_cyc);
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == abort_cyc) begin
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        return;
      end
      chk("frame_txd", uart_txd, line[c / CPB]);
      chk("frame_busy", tx_busy, 1);
      in_valid = (c >= push_cyc) && (c < push_cyc + push_n);
      in_data  = push_d + 8'(c - push_cyc);
      if (c == drop_cyc) tx_en = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    chk("frame_end_busy", tx_busy, 0);
    chk("frame_end_txd", uart_txd, 1);
  endtask

  task automatic idle_frame(input logic [9:0] line);
    chk("gap_busy", tx_busy, 0);
    chk("gap_txd", uart_txd, 1);
    tick();
    frame(line, -1, 8'h00, 0, -1, -1);
  endtask

  task automatic push1(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h55, 10'b1010101010};
    vecs[1] = '{8'hA3, 10'b1101000110};
    vecs[2] = '{8'h00, 10'b1000000000};
    vecs[3] = '{8'hFF, 10'b1111111110};
    vecs[4] = '{8'h81, 10'b1100000010};

    tick();
    tick();
    reset = 1'b0;
    chk("rst_txd", uart_txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_ready2", in_ready2, 1);

    // Single frames from the table, one IDLE cycle after each push
    tx_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push1(vecs[i].data);
      chk("idle_busy", tx_busy, 0);
      chk("idle_txd", uart_txd, 1);
      chk("idle_cnt", fifo_count, 1);
      tick();
      chk("start_cnt", fifo_count, 0);
      frame(vecs[i].line, -1, 8'h00, 0, -1, -1);
    end

    // Fill with tx_en low; fifth push refused and must not overwrite 0x01
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("fill_ready", in_ready, (i < 4));
      in_valid = 1'b1;
      in_data  = 8'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    chk("full_cnt", fifo_count, 4);
    chk("full_ready", in_ready, 0);
    chk("full_busy", tx_busy, 0);
    tx_en = 1'b1;
    tick();
    chk("pop_cnt", fifo_count, 3);
    frame(10'b1000000010, -1, 8'h00, 0, -1, -1);
    idle_frame(10'b1000000100);
    idle_frame(10'b1000000110);
    idle_frame(10'b1000001000);
    chk("drain_cnt", fifo_count, 0);

    // Simultaneous push/pop at count 2 and pointer wrap after 6 pushes
    do_reset();
    tx_en = 1'b1;
    push1(8'h11);
    tick();
    frame(10'b1000100010, 10, 8'h12, 2, -1, -1);
    chk("coinc_pre_cnt", fifo_count, 2);
    in_valid = 1'b1;
    in_data  = 8'h14;
    tick();
    in_valid = 1'b0;
    chk("coinc_cnt", fifo_count, 2);
    frame(10'b1000100100, 20, 8'h15, 2, -1, -1);
    chk("wrap_cnt", fifo_count, 4);
    idle_frame(10'b1000100110);
    idle_frame(10'b1000101000);
    idle_frame(10'b1000101010);
    idle_frame(10'b1000101100);
    chk("wrap_drain_cnt", fifo_count, 0);

    // tx_en dropped mid-frame: frame completes, queue left intact
    do_reset();
    tx_en = 1'b1;
    push1(8'hA3);
    tick();
    frame(10'b1101000110, 5, 8'hB1, 2, 35, -1);
    for (int c = 0; c < 30; c++) begin
      chk("hold_busy", tx_busy, 0);
      chk("hold_txd", uart_txd, 1);
      tick();
    end
    chk("hold_cnt", fifo_count, 2);

    // Reset mid-frame with 3 queued bytes and a push during reset
    do_reset();
    tx_en = 1'b1;
    push1(8'hC5);
    tick();
    frame(10'b1110001010, 5, 8'hD1, 3, -1, 50);
    chk("abort_txd", uart_txd, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_cnt", fifo_count, 0);
    chk("abort_ready", in_ready, 1);
    for (int c = 0; c < 120; c++) begin
      chk("post_abort_busy", tx_busy, 0);
      chk("post_abort_txd", uart_txd, 1);
      tick();
    end

    // 7 data bits, 2 stop bits: 10 start + 70 ones + 20 stop = 100 cycles
    tx_en2    = 1'b1;
    in_valid2 = 1'b1;
    in_data2  = 8'hFF;
    tick();
    in_valid2 = 1'b0;
    chk("p7_idle_busy", tx_busy2, 0);
    chk("p7_idle_cnt", fifo_count2, 1);
    tick();
    for (int c = 0; c < 100; c++) begin
      chk("p7_txd", uart_txd2, (c >= 10));
      chk("p7_busy", tx_busy2, 1);
      tick();
    end
    chk("p7_end_busy", tx_busy2, 0);
    chk("p7_end_txd", uart_txd2, 1);
    chk("p7_end_cnt", fifo_count2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
